// File: rtl/scan_chip_sequencer.sv
// ---------------------------------------------------------------------------------------------
// scan_chip_sequencer
//
// Walks a scan engine through up to NUM_CHIP chips, one at a time. A run is started by a rising
// edge on In_Run_Start. For every enabled chip the sequencer waits for FIFO room, issues a
// START_HOLD-cycle start level, then waits for the engine's end pulse or a millisecond timeout.
// Normal ends are followed by GAP_CYC idle cycles; timeouts and aborts pulse the engine reset.
//
// Ports
//   Clk_10M            in   10 MHz system clock
//   Rst_N              in   asynchronous active-low reset (shared with the scan engine)
//   In_Run_Start       in   level; rising edge starts a run (ignored unless idle)
//   In_Run_Abort       in   level; rising edge aborts the run in progress
//   In_Chip_En[3:0]    in   bit k-1 enables chip k, latched at run start
//   In_Ini_DAC[11:0]   in   initial threshold DAC code, latched at run start
//   In_Scan_End        in   one-cycle end pulse from the scan engine
//   In_Fifo_Prog_Full  in   data FIFO nearly full; blocks the next chip start
//   Out_Scan_Start     out  start level to the scan engine
//   Out_Scan_ID[3:0]   out  chip ID (1..NUM_CHIP) of the active scan
//   Out_Ini_DAC[11:0]  out  DAC code latched at run start
//   Out_Scan_Rst_N     out  active-low reset pulse to the scan engine
//   Out_Busy           out  high while a run is in progress
//   Out_Done           out  one-cycle pulse at normal run completion
//   Out_Chip_Done[3:0] out  bit k-1 set when chip k ended normally
//   Out_Err_Chip[3:0]  out  bit k-1 set when chip k timed out
//   Out_Aborted        out  sticky abort flag, cleared by the next run start
// ---------------------------------------------------------------------------------------------
module scan_chip_sequencer #(
    parameter int unsigned NUM_CHIP   = 4,
    parameter int unsigned START_HOLD = 4,
    parameter int unsigned GAP_CYC    = 10,
    parameter int unsigned MS_DIV     = 10000,
    parameter int unsigned TIMEOUT_MS = 60000
) (
    input  logic        Clk_10M,
    input  logic        Rst_N,
    input  logic        In_Run_Start,
    input  logic        In_Run_Abort,
    input  logic [3:0]  In_Chip_En,
    input  logic [11:0] In_Ini_DAC,
    input  logic        In_Scan_End,
    input  logic        In_Fifo_Prog_Full,
    output logic        Out_Scan_Start,
    output logic [3:0]  Out_Scan_ID,
    output logic [11:0] Out_Ini_DAC,
    output logic        Out_Scan_Rst_N,
    output logic        Out_Busy,
    output logic        Out_Done,
    output logic [3:0]  Out_Chip_Done,
    output logic [3:0]  Out_Err_Chip,
    output logic        Out_Aborted
);

    // Engine reset pulse length after a timeout or abort.
    localparam int unsigned RST_CYC   = 4;
    localparam int unsigned PRE_W     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int unsigned HOLD_LAST = START_HOLD - 1;
    localparam int unsigned GAP_LAST  = GAP_CYC - 1;
    localparam int unsigned RST_LAST  = RST_CYC - 1;
    localparam int unsigned PRE_LAST  = MS_DIV - 1;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StWaitFifo,
        StStart,
        StWaitEnd,
        StGap,
        StResetScan,
        StDone
    } state_e;

    state_e             state;
    logic               start_dly1;
    logic               start_dly2;
    logic               abort_dly1;
    logic               abort_dly2;
    logic               start_edge;
    logic               abort_edge;
    logic               abort_ok;
    logic [3:0]         chip_en_q;
    // One bit wider than the chip ID so it can step past NUM_CHIP.
    logic [4:0]         ptr;
    logic [3:0]         ptr_oh;
    logic               chip_sel;
    logic [15:0]        cnt;
    logic [PRE_W-1:0]   presc;
    logic [15:0]        ms_cnt;

    assign start_edge = start_dly1 & ~start_dly2;
    assign abort_edge = abort_dly1 & ~abort_dly2;

    // Abort is honoured only while a chip sequence is actually running.
    always_comb begin
        abort_ok = 1'b0;
        unique case (state)
            StSelect, StWaitFifo, StStart, StWaitEnd, StGap: abort_ok = 1'b1;
            default:                                         abort_ok = 1'b0;
        endcase
    end

    // Chip k maps to bit k-1 of the enable/status vectors.
    always_comb begin
        ptr_oh = '0;
        for (int i = 0; i < 4; i++) begin
            if (ptr == 5'(i + 1)) begin
                ptr_oh[i] = 1'b1;
            end
        end
    end

    assign chip_sel = |(chip_en_q & ptr_oh);

    always_ff @(posedge Clk_10M or negedge Rst_N) begin
        if (!Rst_N) begin
            state          <= StIdle;
            start_dly1     <= 1'b0;
            start_dly2     <= 1'b0;
            abort_dly1     <= 1'b0;
            abort_dly2     <= 1'b0;
            chip_en_q      <= '0;
            ptr            <= 5'd1;
            cnt            <= '0;
            presc          <= '0;
            ms_cnt         <= '0;
            Out_Scan_Start <= 1'b0;
            Out_Scan_ID    <= '0;
            Out_Ini_DAC    <= 12'hFFF;
            Out_Scan_Rst_N <= 1'b1;
            Out_Busy       <= 1'b0;
            Out_Done       <= 1'b0;
            Out_Chip_Done  <= '0;
            Out_Err_Chip   <= '0;
            Out_Aborted    <= 1'b0;
        end else begin
            start_dly1 <= In_Run_Start;
            start_dly2 <= start_dly1;
            abort_dly1 <= In_Run_Abort;
            abort_dly2 <= abort_dly1;
            Out_Done   <= 1'b0;

            if (abort_edge && abort_ok) begin
                // Abort outranks a same-cycle scan end or timeout.
                Out_Aborted    <= 1'b1;
                Out_Scan_Start <= 1'b0;
                Out_Scan_Rst_N <= 1'b0;
                cnt            <= '0;
                state          <= StResetScan;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start_edge) begin
                            chip_en_q     <= In_Chip_En;
                            Out_Ini_DAC   <= In_Ini_DAC;
                            ptr           <= 5'd1;
                            Out_Chip_Done <= '0;
                            Out_Err_Chip  <= '0;
                            Out_Aborted   <= 1'b0;
                            Out_Busy      <= 1'b1;
                            state         <= StSelect;
                        end
                    end

                    StSelect: begin
                        if (ptr > 5'(NUM_CHIP)) begin
                            state <= StDone;
                        end else if (chip_sel) begin
                            Out_Scan_ID <= ptr[3:0];
                            state       <= StWaitFifo;
                        end else begin
                            ptr <= ptr + 5'd1;
                        end
                    end

                    StWaitFifo: begin
                        if (!In_Fifo_Prog_Full) begin
                            Out_Scan_Start <= 1'b1;
                            cnt            <= '0;
                            presc          <= '0;
                            ms_cnt         <= '0;
                            state          <= StStart;
                        end
                    end

                    StStart: begin
                        if (cnt == 16'(HOLD_LAST)) begin
                            Out_Scan_Start <= 1'b0;
                            state          <= StWaitEnd;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end

                    StWaitEnd: begin
                        if (presc == PRE_W'(PRE_LAST)) begin
                            presc  <= '0;
                            ms_cnt <= ms_cnt + 16'd1;
                        end else begin
                            presc <= presc + PRE_W'(1);
                        end
                        // A scan end in the timeout cycle still counts as a normal end.
                        if (In_Scan_End) begin
                            Out_Chip_Done <= Out_Chip_Done | ptr_oh;
                            cnt           <= '0;
                            state         <= StGap;
                        end else if (ms_cnt == 16'(TIMEOUT_MS)) begin
                            Out_Err_Chip   <= Out_Err_Chip | ptr_oh;
                            Out_Scan_Rst_N <= 1'b0;
                            cnt            <= '0;
                            state          <= StResetScan;
                        end
                    end

                    StGap: begin
                        if (cnt == 16'(GAP_LAST)) begin
                            ptr   <= ptr + 5'd1;
                            state <= StSelect;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end

                    StResetScan: begin
                        if (cnt == 16'(RST_LAST)) begin
                            Out_Scan_Rst_N <= 1'b1;
                            // Out_Aborted tells an abort apart from a timeout here.
                            if (Out_Aborted) begin
                                Out_Busy <= 1'b0;
                                state    <= StIdle;
                            end else begin
                                ptr   <= ptr + 5'd1;
                                state <= StSelect;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end

                    StDone: begin
                        Out_Done <= 1'b1;
                        Out_Busy <= 1'b0;
                        state    <= StIdle;
                    end

                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_chip_sequencer.sv
// ---------------------------------------------------------------------------------------------
// tb_scan_chip_sequencer
//
// Drives runs with random chip enables, DAC codes and scan-engine latencies; a small engine
// model answers each start with an end pulse (or never, to force a timeout). A run-level model
// predicts the scanned IDs and the done/error/abort flags, compared against the observed run.
// ---------------------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scan_chip_sequencer;

    localparam int NUM_CHIP   = 4;
    localparam int START_HOLD = 4;
    localparam int GAP_CYC    = 10;
    localparam int MS_DIV     = 10000;
    localparam int TIMEOUT_MS = 2;
    localparam int RST_CYC    = 4;
    // The ms counter reaches the limit on its last wrap edge and is acted on at the next edge.
    localparam int TO_CYC     = TIMEOUT_MS * MS_DIV + 1;

    logic        Clk_10M;
    logic        Rst_N;
    logic        In_Run_Start;
    logic        In_Run_Abort;
    logic [3:0]  In_Chip_En;
    logic [11:0] In_Ini_DAC;
    logic        In_Scan_End;
    logic        In_Fifo_Prog_Full;
    logic        Out_Scan_Start;
    logic [3:0]  Out_Scan_ID;
    logic [11:0] Out_Ini_DAC;
    logic        Out_Scan_Rst_N;
    logic        Out_Busy;
    logic        Out_Done;
    logic [3:0]  Out_Chip_Done;
    logic [3:0]  Out_Err_Chip;
    logic        Out_Aborted;

    scan_chip_sequencer #(
        .NUM_CHIP   (NUM_CHIP),
        .START_HOLD (START_HOLD),
        .GAP_CYC    (GAP_CYC),
        .MS_DIV     (MS_DIV),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .Clk_10M           (Clk_10M),
        .Rst_N             (Rst_N),
        .In_Run_Start      (In_Run_Start),
        .In_Run_Abort      (In_Run_Abort),
        .In_Chip_En        (In_Chip_En),
        .In_Ini_DAC        (In_Ini_DAC),
        .In_Scan_End       (In_Scan_End),
        .In_Fifo_Prog_Full (In_Fifo_Prog_Full),
        .Out_Scan_Start    (Out_Scan_Start),
        .Out_Scan_ID       (Out_Scan_ID),
        .Out_Ini_DAC       (Out_Ini_DAC),
        .Out_Scan_Rst_N    (Out_Scan_Rst_N),
        .Out_Busy          (Out_Busy),
        .Out_Done          (Out_Done),
        .Out_Chip_Done     (Out_Chip_Done),
        .Out_Err_Chip      (Out_Err_Chip),
        .Out_Aborted       (Out_Aborted)
    );

    initial begin
        Clk_10M = 1'b0;
        forever #50 Clk_10M = ~Clk_10M;
    end

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- observation (sampled 1 ns after each rising edge) ----------------
    int          edge_n;
    int          ids_q[$];
    int          width_q[$];
    int          rise_q[$];
    int          fall_q[$];
    int          rstw_q[$];
    int          rst_fall_q[$];
    int          end_q[$];
    int          done_cnt;
    int          dac_bad;
    int          busy_rise;
    int          busy_fall;
    int          cur_w;
    int          cur_rw;
    logic        p_start;
    logic        p_rst;
    logic        p_busy;
    logic [11:0] exp_dac;

    initial begin
        p_start = 1'b0;
        p_rst   = 1'b1;
        p_busy  = 1'b0;
        forever begin
            @(posedge Clk_10M);
            #1;
            edge_n++;
            if (Out_Scan_Start && !p_start) begin
                ids_q.push_back(int'(Out_Scan_ID));
                rise_q.push_back(edge_n);
                cur_w = 0;
            end
            if (Out_Scan_Start) cur_w++;
            if (!Out_Scan_Start && p_start) begin
                width_q.push_back(cur_w);
                fall_q.push_back(edge_n);
            end
            if (!Out_Scan_Rst_N && p_rst) begin
                rst_fall_q.push_back(edge_n);
                cur_rw = 0;
            end
            if (!Out_Scan_Rst_N) cur_rw++;
            if (Out_Scan_Rst_N && !p_rst) rstw_q.push_back(cur_rw);
            if (Out_Busy && !p_busy) busy_rise = edge_n;
            if (!Out_Busy && p_busy) busy_fall = edge_n;
            if (Out_Done) done_cnt++;
            if (In_Scan_End) end_q.push_back(edge_n);
            if (Out_Busy && Out_Ini_DAC !== exp_dac) dac_bad++;
            p_start = Out_Scan_Start;
            p_rst   = Out_Scan_Rst_N;
            p_busy  = Out_Busy;
        end
    end

    // ---------------- scan engine model: end pulse plan_lat[id] cycles after start falls -----
    int plan_lat[16];

    initial begin
        int   r_cnt;
        logic r_pend;
        logic r_prev;
        In_Scan_End = 1'b0;
        r_cnt  = 0;
        r_pend = 1'b0;
        r_prev = 1'b0;
        forever begin
            @(negedge Clk_10M);
            In_Scan_End = 1'b0;
            if (!Out_Scan_Rst_N) r_pend = 1'b0;
            if (r_pend) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    In_Scan_End = 1'b1;
                    r_pend      = 1'b0;
                end
            end
            if (r_prev && !Out_Scan_Start && Out_Scan_Rst_N && plan_lat[Out_Scan_ID] != 0) begin
                r_cnt  = plan_lat[Out_Scan_ID];
                r_pend = 1'b1;
            end
            r_prev = Out_Scan_Start;
        end
    end

    // ---------------- run helpers ----------------
    int b_ids, b_w, b_rstw, b_rstf, b_done, b_end, b_dac, b_fall;

    task automatic launch(input logic [3:0] en, input logic [11:0] dac);
        @(negedge Clk_10M);
        In_Chip_En = en;
        In_Ini_DAC = dac;
        exp_dac    = dac;
        b_ids  = ids_q.size();
        b_w    = width_q.size();
        b_rstw = rstw_q.size();
        b_rstf = rst_fall_q.size();
        b_done = done_cnt;
        b_end  = end_q.size();
        b_dac  = dac_bad;
        b_fall = fall_q.size();
        In_Run_Start = 1'b1;
        repeat (3) @(negedge Clk_10M);
        In_Run_Start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (Out_Busy === 1'b1 && k < budget) begin
            @(negedge Clk_10M);
            k++;
        end
        check("busy_release", 32'(Out_Busy), 32'd0);
        repeat (5) @(negedge Clk_10M);
    endtask

    // Run-level model: enabled chips in order, stopping at the aborted one.
    task automatic check_run(input logic [3:0] en, input int abort_chip);
        int         exp_ids[$];
        logic [3:0] exp_done;
        logic [3:0] exp_err;
        int         n_to;
        bit         hit_abort;
        exp_done  = '0;
        exp_err   = '0;
        n_to      = 0;
        hit_abort = 1'b0;
        for (int c = 1; c <= NUM_CHIP; c++) begin
            if (!hit_abort && en[c-1]) begin
                exp_ids.push_back(c);
                if (c == abort_chip) begin
                    hit_abort = 1'b1;
                end else if (plan_lat[c] == 0) begin
                    exp_err[c-1] = 1'b1;
                    n_to++;
                end else begin
                    exp_done[c-1] = 1'b1;
                end
            end
        end
        check("n_starts", 32'(ids_q.size() - b_ids), 32'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size(); i++) begin
            if (b_ids + i < ids_q.size())
                check("scan_id", 32'(ids_q[b_ids+i]), 32'(exp_ids[i]));
            if (b_w + i < width_q.size())
                check("start_width", 32'(width_q[b_w+i]), 32'(START_HOLD));
        end
        check("chip_done", 32'(Out_Chip_Done), 32'(exp_done));
        check("err_chip", 32'(Out_Err_Chip), 32'(exp_err));
        check("aborted", 32'(Out_Aborted), 32'(abort_chip != 0));
        check("done_pulses", 32'(done_cnt - b_done), 32'(abort_chip != 0 ? 0 : 1));
        check("rst_pulses", 32'(rstw_q.size() - b_rstw), 32'(n_to + (abort_chip != 0 ? 1 : 0)));
        for (int i = b_rstw; i < rstw_q.size(); i++)
            check("rst_width", 32'(rstw_q[i]), 32'(RST_CYC));
        check("dac_stable", 32'(dac_bad - b_dac), 32'd0);
        check("dac_latched", 32'(Out_Ini_DAC), 32'(exp_dac));
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] en;
        int         k;
        n_checks          = 0;
        n_fail            = 0;
        Rst_N             = 1'b0;
        In_Run_Start      = 1'b0;
        In_Run_Abort      = 1'b0;
        In_Chip_En        = '0;
        In_Ini_DAC        = '0;
        In_Fifo_Prog_Full = 1'b0;
        exp_dac           = 12'hFFF;
        for (int i = 0; i < 16; i++) plan_lat[i] = 50;

        repeat (3) @(negedge Clk_10M);
        check("rst_scan_start", 32'(Out_Scan_Start), 32'd0);
        check("rst_scan_id", 32'(Out_Scan_ID), 32'd0);
        check("rst_ini_dac", 32'(Out_Ini_DAC), 32'hFFF);
        check("rst_scan_rst_n", 32'(Out_Scan_Rst_N), 32'd1);
        check("rst_busy", 32'(Out_Busy), 32'd0);
        check("rst_done", 32'(Out_Done), 32'd0);
        check("rst_chip_done", 32'(Out_Chip_Done), 32'd0);
        check("rst_err_chip", 32'(Out_Err_Chip), 32'd0);
        check("rst_aborted", 32'(Out_Aborted), 32'd0);
        Rst_N = 1'b1;
        repeat (3) @(negedge Clk_10M);

        // All chips, fixed 50-cycle engine latency.
        launch(4'b1111, 12'h100);
        wait_idle(2000);
        check_run(4'b1111, 0);
        // Scan end -> next start: GAP_CYC idle cycles, then one select and one FIFO-check cycle.
        for (int i = 0; i < 3; i++) begin
            if (b_ids + i + 1 < rise_q.size() && b_end + i < end_q.size())
                check("gap_timing", 32'(rise_q[b_ids+i+1] - end_q[b_end+i]), 32'(GAP_CYC + 2));
        end

        // Chips 2 and 4 only.
        for (int c = 1; c <= 4; c++) plan_lat[c] = $urandom_range(1, 80);
        launch(4'b1010, 12'($urandom_range(0, 4095)));
        wait_idle(2000);
        check_run(4'b1010, 0);

        // No chips: NUM_CHIP+1 select cycles plus the done cycle.
        launch(4'b0000, 12'h5A5);
        wait_idle(100);
        check_run(4'b0000, 0);
        check("empty_run_len", 32'(busy_fall - busy_rise), 32'(NUM_CHIP + 2));

        // Random enables, DAC codes and latencies.
        for (int r = 0; r < 6; r++) begin
            for (int c = 1; c <= 4; c++) plan_lat[c] = $urandom_range(1, 80);
            en = 4'($urandom_range(0, 15));
            launch(en, 12'($urandom_range(0, 4095)));
            wait_idle(2000);
            check_run(en, 0);
        end

        // Chip 1 never ends: timeout, engine reset, then chip 2.
        plan_lat[1] = 0;
        plan_lat[2] = 30;
        launch(4'b0011, 12'h2C3);
        wait_idle(TO_CYC + 2000);
        check_run(4'b0011, 0);
        if (b_rstf < rst_fall_q.size() && b_fall < fall_q.size())
            check("timeout_latency", 32'(rst_fall_q[b_rstf] - fall_q[b_fall]), 32'(TO_CYC));
        else
            check("timeout_seen", 32'(rst_fall_q.size() - b_rstf), 32'd1);

        // Abort while chip 2 waits for its end pulse.
        for (int c = 1; c <= 4; c++) plan_lat[c] = 50;
        plan_lat[2] = 5000;
        launch(4'b1111, 12'h0F0);
        k = 0;
        while (width_q.size() < b_w + 2 && k < 5000) begin
            @(negedge Clk_10M);
            k++;
        end
        check("chip2_started", 32'(width_q.size() >= b_w + 2), 32'd1);
        repeat (20) @(negedge Clk_10M);
        In_Run_Abort = 1'b1;
        repeat (3) @(negedge Clk_10M);
        In_Run_Abort = 1'b0;
        wait_idle(1000);
        check_run(4'b1111, 2);

        // FIFO nearly full before chip 1: no start until it drops, then start on that edge.
        plan_lat[1] = 20;
        In_Fifo_Prog_Full = 1'b1;
        launch(4'b0001, 12'h321);
        repeat (100) @(negedge Clk_10M);
        check("fifo_hold_start", 32'(Out_Scan_Start), 32'd0);
        check("fifo_hold_count", 32'(ids_q.size() - b_ids), 32'd0);
        In_Fifo_Prog_Full = 1'b0;
        @(posedge Clk_10M);
        #1;
        check("fifo_release_start", 32'(Out_Scan_Start), 32'd1);
        wait_idle(1000);
        check_run(4'b0001, 0);

        // Scan end lands exactly in the timeout cycle: counts as done.
        plan_lat[1] = TO_CYC - 1;
        launch(4'b0001, 12'h777);
        wait_idle(TO_CYC + 2000);
        check_run(4'b0001, 0);

        // Abort edge lands in the same cycle as the scan end: abort wins.
        plan_lat[1] = 30;
        launch(4'b0001, 12'h888);
        k = 0;
        while (width_q.size() < b_w + 1 && k < 1000) begin
            @(negedge Clk_10M);
            k++;
        end
        check("coinc_started", 32'(width_q.size() >= b_w + 1), 32'd1);
        // Abort passes two flops, so raise it one cycle before the end pulse is driven.
        repeat (29) @(negedge Clk_10M);
        In_Run_Abort = 1'b1;
        repeat (3) @(negedge Clk_10M);
        In_Run_Abort = 1'b0;
        wait_idle(1000);
        check_run(4'b0001, 1);

        // Reset mid-run: immediate, no done pulse.
        for (int c = 1; c <= 4; c++) plan_lat[c] = 50;
        launch(4'b1111, 12'h3A5);
        repeat (30) @(negedge Clk_10M);
        b_done = done_cnt;
        Rst_N  = 1'b0;
        #1;
        check("midrst_busy", 32'(Out_Busy), 32'd0);
        check("midrst_start", 32'(Out_Scan_Start), 32'd0);
        check("midrst_dac", 32'(Out_Ini_DAC), 32'hFFF);
        repeat (5) @(negedge Clk_10M);
        Rst_N = 1'b1;
        repeat (20) @(negedge Clk_10M);
        check("midrst_no_done", 32'(done_cnt - b_done), 32'd0);
        check("midrst_idle", 32'(Out_Busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_chip_sequencer.md
SCAN_CHIP_SEQUENCER -- requirements
Module: scan_chip_sequencer

Interface
REQ-001 Parameters SHALL be: NUM_CHIP, 4, number of chips scanned; START_HOLD, 4, cycles Out_Scan_Start is held high; GAP_CYC, 10, idle cycles between chips; MS_DIV, 10000, clock cycles per 1 ms tick; TIMEOUT_MS, 60000, per-chip scan timeout in ms.
REQ-002 Clk_10M  in  1  system clock, 10 MHz.
REQ-003 Rst_N  in  1  reset, asynchronous, active-low.
REQ-004 In_Run_Start  in  1  level; a rising edge starts a run.
REQ-005 In_Run_Abort  in  1  level; a rising edge aborts the run.
REQ-006 In_Chip_En  in  4  bit k enables chip k (k = 1..4).
REQ-007 In_Ini_DAC  in  12  initial threshold DAC code forwarded to the scan engine.
REQ-008 In_Scan_End  in  1  one-cycle end pulse from the scan engine.
REQ-009 In_Fifo_Prog_Full  in  1  data FIFO nearly full; the next chip is not started while this is high.
REQ-010 Out_Scan_Start  out  1  start level to the scan engine.
REQ-011 Out_Scan_ID  out  4  chip ID (1..NUM_CHIP) of the active scan.
REQ-012 Out_Ini_DAC  out  12  DAC code latched at run start.
REQ-013 Out_Scan_Rst_N  out  1  active-low reset to the scan engine.
REQ-014 Out_Busy  out  1  high while a run is in progress.
REQ-015 Out_Done  out  1  one-cycle pulse at normal run completion.
REQ-016 Out_Chip_Done  out  4  bit k set when chip k ends normally.
REQ-017 Out_Err_Chip  out  4  bit k set when chip k times out.
REQ-018 Out_Aborted  out  1  sticky; set on abort.

Function
REQ-019 In_Run_Start and In_Run_Abort SHALL each pass through a two-flop delay; an edge is Delay1 && !Delay2.
REQ-020 States SHALL be IDLE, SELECT, WAIT_FIFO, START, WAIT_END, GAP, RESET_SCAN and DONE.
REQ-021 IDLE: on a start edge, latch In_Chip_En and In_Ini_DAC, set ptr=1, clear Out_Chip_Done, Out_Err_Chip and Out_Aborted, set Out_Busy=1, then go to SELECT. Start edges in any other state are ignored.
REQ-022 SELECT: one chip is evaluated per cycle.
- ptr > NUM_CHIP -> DONE.
- Latched enable bit [ptr] = 1 -> WAIT_FIFO, with Out_Scan_ID = ptr.
- Otherwise ptr increments and the state stays in SELECT.
REQ-023 WAIT_FIFO: stay while In_Fifo_Prog_Full = 1; otherwise go to START.
REQ-024 START: drive Out_Scan_Start=1 for exactly START_HOLD cycles, then drive it 0 and go to WAIT_END. Clear the ms prescaler and the ms counter on entry.
REQ-025 WAIT_END: the prescaler counts 0..MS_DIV-1 and increments the ms counter (16-bit) on wrap.
- In_Scan_End = 1: set Out_Chip_Done[ptr] -> GAP.
- ms counter == TIMEOUT_MS: set Out_Err_Chip[ptr] -> RESET_SCAN.
- If both occur in the same cycle, In_Scan_End wins.
REQ-026 GAP: wait GAP_CYC cycles, then ptr increments -> SELECT.
REQ-027 RESET_SCAN: drive Out_Scan_Rst_N=0 for 4 cycles, then release it.
- After a timeout: ptr increments -> GAP-free return to SELECT.
- After an abort: -> IDLE, with Out_Busy=0 and no Out_Done pulse.
REQ-028 An abort edge in any state other than IDLE, DONE or RESET_SCAN SHALL set Out_Aborted and go to RESET_SCAN; it takes priority over In_Scan_End and timeout in the same cycle. An abort edge in IDLE is ignored.
REQ-029 DONE: pulse Out_Done for 1 cycle, set Out_Busy=0 -> IDLE.
REQ-030 Out_Chip_Done, Out_Err_Chip and Out_Aborted SHALL hold their values after the run until the next start edge.
REQ-031 A run with no chip enabled SHALL reach DONE after NUM_CHIP+1 SELECT cycles without asserting Out_Scan_Start.

Reset
REQ-032 Asynchronous reset SHALL force the following:
- State IDLE, ptr=1, all counters 0.
- Out_Scan_Start=0, Out_Scan_ID=0, Out_Ini_DAC=12'hFFF.
- Out_Scan_Rst_N=1, Out_Busy=0, Out_Done=0.
- Out_Chip_Done=0, Out_Err_Chip=0, Out_Aborted=0.
REQ-033 Reset asserted mid-run SHALL abort the run immediately without an Out_Done pulse. The scan engine shares Rst_N and is not reset separately.

Verification
REQ-034 Chip_En=4'b1111, DAC=12'h100, In_Scan_End returned 50 cycles after each start falls -> IDs 1,2,3,4 issued in order; Out_Chip_Done=4'b1111; one Out_Done pulse; Out_Ini_DAC=12'h100 throughout.
REQ-035 Chip_En=4'b1010 -> only IDs 2 and 4 are started, each with a 4-cycle start pulse; Out_Chip_Done=4'b1010.
REQ-036 TIMEOUT_MS=2, chip 1 never ends -> Out_Scan_Rst_N low for 4 cycles at 20000 cycles; Out_Err_Chip[1]=1; the chip-2 scan follows.
REQ-037 Abort edge during WAIT_END of chip 2 -> Out_Scan_Rst_N pulses low; Out_Aborted=1; Out_Busy=0; no Out_Done pulse; chips 3 and 4 are not started.
REQ-038 In_Fifo_Prog_Full held high for 100 cycles before chip 1 -> Out_Scan_Start stays 0 until it drops, then rises within 1 cycle of leaving WAIT_FIFO.
REQ-039 In_Scan_End coincident with the timeout cycle -> chip counted done, Err bit 0; same cycle with abort -> aborted.
